// File: rtl/fast_inv_sqrt_nr.sv
// rtl/fast_inv_sqrt_nr.sv - half-precision 1/sqrt(x) / sqrt(x) via bit hack plus Newton-Raphson
// Contains the sequencer top and the shared single-cycle-latency fpu_16bit it drives.

module fpu_16bit (
  output logic [1:0]  OFUF,
  output logic        done,
  output logic [15:0] result,
  output logic        compResult,
  input  logic [15:0] xOp,
  input  logic [15:0] yOp,
  input  logic [1:0]  opcode,
  input  logic        reset,
  input  logic        clk
);
  logic [4:0]  ea, eb;
  logic [13:0] ma, mb, mbig, msml;
  logic [14:0] acc;
  logic [21:0] prod;
  logic [10:0] sig;
  logic [11:0] rnd;
  logic [9:0]  mant;
  logic        sa, sb, sr, rb, zero;
  logic [15:0] res_c;
  logic [1:0]  flg_c;
  int          e;

  // Subnormal operands flush to zero; results round to nearest (ties away).
  always_comb begin
    ea = xOp[14:10];
    eb = yOp[14:10];
    ma = (ea != 5'd0) ? {1'b1, xOp[9:0], 3'b000} : 14'd0;
    mb = (eb != 5'd0) ? {1'b1, yOp[9:0], 3'b000} : 14'd0;
    sa = xOp[15];
    sb = yOp[15] ^ (opcode == 2'd1);
    prod = '0; acc = '0; mbig = '0; msml = '0;
    sig = '0; rb = 1'b0; sr = 1'b0; zero = 1'b0; e = 0;
    if (opcode == 2'd2) begin
      sr = sa ^ yOp[15];
      zero = (ea == 5'd0) || (eb == 5'd0);
      prod = {11'd0, ma[13:3]} * {11'd0, mb[13:3]};
      e = int'(ea) + int'(eb) - 15;
      if (prod[21]) begin sig = prod[21:11]; rb = prod[10]; e = e + 1; end
      else begin sig = prod[20:10]; rb = prod[9]; end
    end else begin
      if ({ea, xOp[9:0]} >= {eb, yOp[9:0]}) begin
        mbig = ma; msml = mb >> (ea - eb); e = int'(ea); sr = sa;
      end else begin
        mbig = mb; msml = ma >> (eb - ea); e = int'(eb); sr = sb;
      end
      acc = (sa == sb) ? {1'b0, mbig} + {1'b0, msml} : {1'b0, mbig} - {1'b0, msml};
      zero = (acc == '0);
      if (acc[14]) begin sig = acc[14:4]; rb = acc[3]; e = e + 1; end
      else begin
        for (int i = 0; i < 14; i++)
          if (!acc[13] && !zero) begin acc = acc << 1; e = e - 1; end
        sig = acc[13:3]; rb = acc[2];
      end
    end
    rnd = {1'b0, sig} + {11'd0, rb};
    if (rnd[11]) e = e + 1;
    mant = rnd[11] ? rnd[10:1] : rnd[9:0];
    res_c = {sr, e[4:0], mant};
    flg_c = 2'b00;
    if (zero) res_c = 16'h0000;
    else if (e >= 31) begin res_c = {sr, 15'h7C00}; flg_c = 2'b10; end
    else if (e <= 0) begin res_c = {sr, 15'h0000}; flg_c = 2'b01; end
  end

  always_ff @(posedge clk) begin
    done <= reset;
    if (reset) begin
      result     <= res_c;
      OFUF       <= flg_c;
      compResult <= res_c[15];
    end
  end
endmodule

module fast_inv_sqrt_nr #(
  parameter int          NR_ITER = 1,
  parameter logic [15:0] MAGIC   = 16'h59BB,
  parameter logic [15:0] HALF_15 = 16'h3E00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic        in_mode,
  output logic        out_valid,
  output logic [15:0] out_result,
  output logic [1:0]  out_flags,
  output logic        busy
);
  if (NR_ITER < 1 || NR_ITER > 4) begin : g_bad_nr_iter
    $error("fast_inv_sqrt_nr: NR_ITER must be in 1..4");
  end

  typedef enum logic [3:0] {S_IDLE, S_CHECK, S_SQ, S_MH, S_SB, S_MY, S_SX, S_FIN, S_DONE} state_t;
  state_t      state, state_n;
  logic        wt, wt_n, mr, op_state, fpu_err, last_iter;
  logic [2:0]  iter;
  logic [15:0] xr, y, t, xh;
  logic [16:0] bh;
  logic        fpu_start, fpu_done, fpu_cmp, chk_hit;
  logic [1:0]  fpu_ofuf, fpu_op, chk_flg;
  logic [15:0] fpu_res, fpu_x, fpu_y, chk_res;

  assign bh        = {1'b0, MAGIC} - {1'b0, xr >> 1};
  assign xh        = {xr[15], xr[14:10] - 5'd1, xr[9:0]};
  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign op_state  = state inside {S_SQ, S_MH, S_SB, S_MY, S_SX};
  assign fpu_err   = op_state && wt && (fpu_ofuf == 2'b10 || fpu_ofuf == 2'b01);
  assign last_iter = (iter + 3'd1) >= 3'(NR_ITER);

  always_comb begin
    chk_hit = 1'b1; chk_res = 16'h0000; chk_flg = 2'b00;
    if (xr == 16'h0000) begin chk_res = 16'h7C00; chk_flg = 2'b10; end
    else if (xr[15]) begin chk_res = 16'h7E00; chk_flg = 2'b11; end
    else if (xr == 16'h3C00) chk_res = 16'h3C00;
    else if (xr[14:10] == 5'd0) chk_flg = 2'b01;
    else if (bh[16]) chk_flg = 2'b10;
    else chk_hit = 1'b0;
  end

  always_comb begin
    fpu_x = y; fpu_y = y; fpu_op = 2'd2;
    case (state)
      S_MH: begin fpu_x = xh; fpu_y = t; end
      S_SB: begin fpu_x = HALF_15; fpu_y = t; fpu_op = 2'd1; end
      S_MY: begin fpu_x = y; fpu_y = t; end
      S_SX: begin fpu_x = xr; fpu_y = y; end
      default: ;
    endcase
  end

  // Each op state: first cycle issues (wt=0), then waits for done (wt=1).
  always_comb begin
    state_n = state; wt_n = wt; fpu_start = 1'b0;
    case (state)
      S_IDLE:  if (in_valid) state_n = S_CHECK;
      S_CHECK: begin state_n = chk_hit ? S_DONE : S_SQ; wt_n = 1'b0; end
      S_SQ, S_MH, S_SB, S_MY, S_SX: begin
        if (!wt) begin fpu_start = 1'b1; wt_n = 1'b1; end
        else if (fpu_err) begin state_n = S_DONE; wt_n = 1'b0; end
        else if (fpu_done) begin
          wt_n = 1'b0;
          case (state)
            S_SQ:    state_n = S_MH;
            S_MH:    state_n = S_SB;
            S_SB:    state_n = S_MY;
            S_MY:    state_n = !last_iter ? S_SQ : (mr ? S_SX : S_FIN);
            default: state_n = S_FIN;
          endcase
        end
      end
      S_FIN:   state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE; wt <= 1'b0; iter <= 3'd0; mr <= 1'b0;
      xr <= '0; y <= '0; t <= '0;
      out_valid <= 1'b0; out_result <= '0; out_flags <= 2'b00;
    end else begin
      state <= state_n; wt <= wt_n; out_valid <= 1'b0;
      if (state == S_IDLE && in_valid) begin xr <= in_x; mr <= in_mode; iter <= 3'd0; end
      if (state == S_CHECK) begin
        if (chk_hit) begin out_valid <= 1'b1; out_result <= chk_res; out_flags <= chk_flg; end
        else y <= bh[15:0];
      end
      if (fpu_err) begin out_valid <= 1'b1; out_result <= '0; out_flags <= fpu_ofuf; end
      else if (op_state && wt && fpu_done) begin
        case (state)
          S_SQ, S_MH, S_SB: t <= fpu_res;
          S_MY:    begin y <= fpu_res; iter <= iter + 3'd1; end
          default: y <= fpu_res;
        endcase
      end
      if (state == S_FIN) begin out_valid <= 1'b1; out_result <= y; out_flags <= 2'b00; end
    end
  end

  // 1.5 - x/2*y^2 stays positive for any estimate the bit hack can produce.
  always_ff @(posedge clk)
    if (reset && state == S_SB && wt && fpu_done && !fpu_err) assert (!fpu_cmp);

  fpu_16bit u_fpu (fpu_ofuf, fpu_done, fpu_res, fpu_cmp, fpu_x, fpu_y, fpu_op, fpu_start, clk);
endmodule

// File: tb/tb_fast_inv_sqrt_nr.sv
// tb/tb_fast_inv_sqrt_nr.sv - self-checking bench for fast_inv_sqrt_nr (NR_ITER=2)
module tb_fast_inv_sqrt_nr;
  localparam int NR = 2;

  logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_mode = 1'b0;
  logic [15:0] in_x = 16'h0000;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_result;
  logic [1:0]  out_flags;

  fast_inv_sqrt_nr #(.NR_ITER(NR)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_mode(in_mode), .out_valid(out_valid),
    .out_result(out_result), .out_flags(out_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  function automatic void check(string nm, bit ok, logic [31:0] act, logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real s;
    int  e;
    s = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    if (e > 0) repeat (e) s = s * 2.0;
    else repeat (-e) s = s / 2.0;
    return h[15] ? -s : s;
  endfunction

  function automatic void model(input logic [15:0] x, input logic m, output bit special,
                                output logic [15:0] r, output logic [1:0] f, output real ref_v);
    special = 1'b1; r = 16'h0000; f = 2'b00; ref_v = 0.0;
    if (x == 16'h0000) begin r = 16'h7C00; f = 2'b10; end
    else if (x[15]) begin r = 16'h7E00; f = 2'b11; end
    else if (x == 16'h3C00) r = 16'h3C00;
    else if (x[14:10] == 5'd0) f = 2'b01;
    else begin
      special = 1'b0;
      ref_v = m ? $sqrt(h2r(x)) : 1.0 / $sqrt(h2r(x));
    end
  endfunction

  function automatic int exp_lat(input bit special, input logic m);
    return special ? 2 : 3 + 2 * (4 * NR + int'(m));
  endfunction

  task automatic run_job(input logic [15:0] x, input logic m, input int poke_at,
                         output logic [15:0] r, output logic [1:0] f, output int lat,
                         output bit overlap, output bit poke_ready);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    in_valid = 1'b1; in_x = x; in_mode = m;
    lat = 0; overlap = 1'b0; poke_ready = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
      if (lat == poke_at) begin
        in_valid = 1'b1; in_x = 16'h0000;
        if (in_ready) poke_ready = 1'b1;
      end
      if (out_valid && in_ready) overlap = 1'b1;
    end while (!out_valid && lat < 200);
    in_valid = 1'b0;
    r = out_result; f = out_flags;
    if (!out_valid) lat = -1;
  endtask

  typedef struct {
    logic [15:0] x;
    logic        m;
    logic [15:0] res;
    logic [1:0]  flg;
    int          tol;
    bit          special;
  } vec_t;
  vec_t vt[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r, er;
    logic [1:0]  f, ef;
    int          lat, d, okcnt;
    bit          ov, pr, sp;
    real         rv, err;

    vt[0] = '{16'h3C00, 1'b0, 16'h3C00, 2'b00, 0, 1'b1};
    vt[1] = '{16'h4400, 1'b0, 16'h3800, 2'b00, 2, 1'b0};
    vt[2] = '{16'h4880, 1'b1, 16'h4200, 2'b00, 2, 1'b0};
    vt[3] = '{16'h0000, 1'b0, 16'h7C00, 2'b10, 0, 1'b1};
    vt[4] = '{16'hC400, 1'b0, 16'h7E00, 2'b11, 0, 1'b1};
    vt[5] = '{16'h0200, 1'b0, 16'h0000, 2'b01, 0, 1'b1};
    vt[6] = '{16'h8000, 1'b1, 16'h7E00, 2'b11, 0, 1'b1};
    vt[7] = '{16'h3C00, 1'b1, 16'h3C00, 2'b00, 0, 1'b1};

    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready == 1'b1, in_ready, 1);
    check("reset_busy", busy == 1'b0, busy, 0);
    check("reset_out_valid", out_valid == 1'b0, out_valid, 0);
    check("reset_result", out_result == 16'h0000, out_result, 0);
    check("reset_flags", out_flags == 2'b00, out_flags, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_job(vt[i].x, vt[i].m, -1, r, f, lat, ov, pr);
      d = int'(r) - int'(vt[i].res);
      if (d < 0) d = -d;
      check($sformatf("vec%0d_result", i), d <= vt[i].tol, r, vt[i].res);
      check($sformatf("vec%0d_flags", i), f == vt[i].flg, f, vt[i].flg);
      check($sformatf("vec%0d_latency", i), lat == exp_lat(vt[i].special, vt[i].m), lat,
            exp_lat(vt[i].special, vt[i].m));
      check($sformatf("vec%0d_overlap", i), !ov, ov, 0);
      @(negedge clk);
      check($sformatf("vec%0d_ready_after", i), in_ready == 1'b1, in_ready, 1);
    end

    // In_valid pulse mid-job must be ignored.
    run_job(16'h4400, 1'b0, 4, r, f, lat, ov, pr);
    d = int'(r) - 16'h3800;
    if (d < 0) d = -d;
    check("poke_ready_low", !pr, pr, 0);
    check("poke_result", d <= 2, r, 16'h3800);
    check("poke_latency", lat == exp_lat(1'b0, 1'b0), lat, exp_lat(1'b0, 1'b0));
    @(negedge clk);

    // Reset during the MH wait cycle (accept+5), then a clean job.
    in_valid = 1'b1; in_x = 16'h4400; in_mode = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("midjob_busy", busy == 1'b1, busy, 1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready == 1'b1, in_ready, 1);
    check("midrst_busy", busy == 1'b0, busy, 0);
    check("midrst_out_valid", out_valid == 1'b0, out_valid, 0);
    check("midrst_result", out_result == 16'h0000, out_result, 0);
    reset = 1'b1;
    okcnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) okcnt++;
    end
    check("midrst_no_out_valid", okcnt == 0, okcnt, 0);
    run_job(16'h4400, 1'b0, -1, r, f, lat, ov, pr);
    d = int'(r) - 16'h3800;
    if (d < 0) d = -d;
    check("after_rst_result", d <= 2, r, 16'h3800);
    check("after_rst_flags", f == 2'b00, f, 0);
    check("after_rst_latency", lat == exp_lat(1'b0, 1'b0), lat, exp_lat(1'b0, 1'b0));
    @(negedge clk);

    for (int n = 0; n < 24; n++) begin
      logic [15:0] x;
      logic        m;
      int          cat;
      cat = int'($urandom_range(0, 9));
      m = 1'($urandom_range(0, 1));
      if (cat < 7) x = {1'b0, 5'($urandom_range(3, 26)), 10'($urandom)};
      else if (cat == 7) x = 16'h0000;
      else if (cat == 8) x = {1'b1, 15'($urandom)};
      else x = {6'b000000, 10'($urandom_range(1, 1023))};
      model(x, m, sp, er, ef, rv);
      run_job(x, m, -1, r, f, lat, ov, pr);
      check($sformatf("rnd%0d_flags x=%h m=%0d", n, x, m), f == ef, f, ef);
      check($sformatf("rnd%0d_latency", n), lat == exp_lat(sp, m), lat, exp_lat(sp, m));
      check($sformatf("rnd%0d_overlap", n), !ov, ov, 0);
      if (sp) check($sformatf("rnd%0d_result x=%h", n, x), r == er, r, er);
      else begin
        err = (h2r(r) - rv) / rv;
        if (err < 0.0) err = -err;
        checks++;
        if (!(err < 0.005)) begin
          failures++;
          $display("FAIL rnd%0d_result x=%h m=%0d actual=%h (%f) required~%f", n, x, m, r, h2r(r), rv);
        end
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
